// File: rtl/qoi_dma_ctrl.sv
// Bus-master byte-copy DMA for the 65C02 bus: stalls the CPU via RDY, copies LEN bytes SRC->DST
// at 3 cycles/byte (read, read-wait, write), then releases the bus and flags done/IRQ.
module qoi_dma_ctrl #(
    parameter int AW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [2:0]    addr,
    input  logic [7:0]    data_i,
    output logic [7:0]    data_o,
    input  logic          cpu_we,
    output logic          cpu_rdy,
    output logic          bus_sel,
    output logic [AW-1:0] dma_addr,
    output logic [7:0]    dma_do,
    output logic          dma_we,
    input  logic [7:0]    dma_di,
    output logic          irq
);

    typedef enum logic [2:0] {IDLE, REQ, RD, RDW, WR, REL} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] src, dst;
    logic [LW-1:0] len;
    logic          ie, dst_fix, src_fix, done;
    logic          busy, ctrl_wr, start_req, abort_req;
    logic [7:0]    rd_val;

    assign busy      = (state != IDLE);
    assign ctrl_wr   = cs & we & (addr == 3'd6);
    assign start_req = ctrl_wr & data_i[0];
    assign abort_req = ctrl_wr & ~data_i[0];
    assign irq       = done & ie;

    always_comb begin
        state_nx = state;
        bus_sel  = 1'b0;
        dma_we   = 1'b0;
        dma_addr = '0;
        case (state)
            IDLE: if (start_req && len != '0) state_nx = REQ;
            // Only take the bus while the CPU sits in a read cycle, which it can safely repeat.
            REQ:  if (abort_req)   state_nx = REL;
                  else if (!cpu_we) state_nx = RD;
            RD: begin
                bus_sel  = 1'b1;
                dma_addr = src;
                state_nx = abort_req ? REL : RDW;
            end
            RDW: begin
                bus_sel  = 1'b1;
                dma_addr = src;
                state_nx = abort_req ? REL : WR;
            end
            // An abort arriving here still lets this byte's write complete.
            WR: begin
                bus_sel  = 1'b1;
                dma_we   = 1'b1;
                dma_addr = dst;
                state_nx = (len == LW'(1) || abort_req) ? REL : RD;
            end
            REL:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_val = 8'h00;
        case (addr)
            3'd0: rd_val = src[7:0];
            3'd1: rd_val = 8'(src >> 8);
            3'd2: rd_val = dst[7:0];
            3'd3: rd_val = 8'(dst >> 8);
            3'd4: rd_val = len[7:0];
            3'd5: rd_val = 8'(len >> 8);
            3'd6: rd_val = {4'h0, ie, dst_fix, src_fix, busy};
            3'd7: rd_val = {6'h00, done, busy};
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            ie      <= 1'b0;
            dst_fix <= 1'b0;
            src_fix <= 1'b0;
            done    <= 1'b0;
            cpu_rdy <= 1'b1;
            dma_do  <= 8'h00;
            data_o  <= 8'h00;
        end else begin
            state <= state_nx;

            // RDY returns one cycle after the bus is handed back, giving the CPU a stable bus.
            if (state == IDLE)
                cpu_rdy <= (state_nx == IDLE);

            if (cs && !we && !bus_sel)
                data_o <= rd_val;

            if (cs && we && !busy) begin
                case (addr)
                    3'd0: src <= AW'({src >> 8, data_i});
                    3'd1: src <= AW'({data_i, src[7:0]});
                    3'd2: dst <= AW'({dst >> 8, data_i});
                    3'd3: dst <= AW'({data_i, dst[7:0]});
                    3'd4: len <= LW'({len >> 8, data_i});
                    3'd5: len <= LW'({data_i, len[7:0]});
                    3'd6: begin
                        {ie, dst_fix, src_fix} <= data_i[3:1];
                        done <= data_i[0] && (len == '0);
                    end
                    default: ;
                endcase
            end else if (abort_req && busy) begin
                {ie, dst_fix, src_fix} <= data_i[3:1];
                done <= 1'b0;
            end

            if (state == RDW)
                dma_do <= dma_di;

            if (state == WR) begin
                src <= src + AW'(!src_fix);
                dst <= dst + AW'(!dst_fix);
                len <= len - LW'(1);
            end

            if (state == REL)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qoi_dma_ctrl.sv
// Bench for qoi_dma_ctrl: synchronous memory model plus a write scoreboard of expected {addr,data}.
module tb_qoi_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, we = 1'b0, cpu_we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [7:0]  data_i = 8'h00;
    logic [7:0]  data_o, dma_do, dma_di;
    logic        cpu_rdy, bus_sel, dma_we, irq;
    logic [15:0] dma_addr;

    logic [7:0]  mem [0:65535];
    logic [23:0] exp_q [$];
    int          total = 0, bad = 0;
    int          stall_cnt = 0, sel_cnt = 0;
    logic        prev_we = 1'b0;
    logic [7:0]  rv;
    logic [7:0]  bytes [0:4];

    qoi_dma_ctrl #(.AW(16), .LW(16)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .data_i(data_i),
        .data_o(data_o), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy), .bus_sel(bus_sel),
        .dma_addr(dma_addr), .dma_do(dma_do), .dma_we(dma_we), .dma_di(dma_di), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dma_di <= mem[dma_addr];
        if (bus_sel && dma_we) mem[dma_addr] = dma_do;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] e;
        if (!cpu_rdy) stall_cnt++;
        if (bus_sel) sel_cnt++;
        if (dma_we) begin
            chk("we_pulse", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexp_wr", {16'h0, dma_addr}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {16'h0, dma_addr}, {16'h0, e[23:8]});
                chk("wr_data", {24'h0, dma_do}, {24'h0, e[7:0]});
            end
        end
        prev_we = dma_we;
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; data_i = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = data_o;
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] t, input logic [15:0] n);
        wr(3'd0, s[7:0]); wr(3'd1, s[15:8]);
        wr(3'd2, t[7:0]); wr(3'd3, t[15:8]);
        wr(3'd4, n[7:0]); wr(3'd5, n[15:8]);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cpu_rdy) break;
        end
        if (i == 300) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_we();
        int i;
        for (i = 0; i < 300 && !dma_we; i++) @(negedge clk);
        if (!dma_we) chk("we_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("rst_sel", {31'd0, bus_sel}, 32'd0);
        chk("rst_we", {31'd0, dma_we}, 32'd0);
        chk("rst_addr", {16'h0, dma_addr}, 32'd0);
        chk("rst_do", {24'h0, dma_do}, 32'd0);
        chk("rst_data_o", {24'h0, data_o}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rd(3'(r), rv);
            chk("rst_reg", {24'h0, rv}, 32'd0);
        end

        // Plain 4-byte copy 0x9000 -> 0x8000
        for (int i = 0; i < 4; i++) begin
            bytes[i] = 8'($urandom_range(1, 255));
            mem[16'h9000 + i] = bytes[i];
            exp_q.push_back({16'h8000 + 16'(i), bytes[i]});
        end
        setup(16'h9000, 16'h8000, 16'd4);
        stall_cnt = 0;
        wr(3'd6, 8'h01);
        wait_idle();
        chk("copy_stall", stall_cnt, 32'd15);
        for (int i = 0; i < 4; i++) chk("copy_mem", {24'h0, mem[16'h8000 + i]}, {24'h0, bytes[i]});
        rd(3'd7, rv); chk("copy_status", {24'h0, rv}, 32'h02);
        chk("copy_irq_off", {31'd0, irq}, 32'd0);
        rd(3'd4, rv); chk("copy_len", {24'h0, rv}, 32'h00);
        rd(3'd0, rv); chk("copy_src_lo", {24'h0, rv}, 32'h04);

        // Fixed destination (accelerator window), ie set
        mem[16'h9100] = 8'h11; mem[16'h9101] = 8'h22; mem[16'h9102] = 8'h33;
        exp_q.push_back({16'hA000, 8'h11});
        exp_q.push_back({16'hA000, 8'h22});
        exp_q.push_back({16'hA000, 8'h33});
        setup(16'h9100, 16'hA000, 16'd3);
        wr(3'd6, 8'h0D);
        wait_idle();
        chk("fix_irq", {31'd0, irq}, 32'd1);
        rd(3'd2, rv); chk("fix_dst_lo", {24'h0, rv}, 32'h00);
        rd(3'd3, rv); chk("fix_dst_hi", {24'h0, rv}, 32'hA0);
        wr(3'd6, 8'h08);
        chk("ctrl_clears_done", {31'd0, irq}, 32'd0);

        // LEN = 0 start: done immediately, bus never taken
        stall_cnt = 0; sel_cnt = 0;
        wr(3'd6, 8'h09);
        chk("len0_irq", {31'd0, irq}, 32'd1);
        rd(3'd7, rv); chk("len0_status", {24'h0, rv}, 32'h02);
        rd(3'd7, rv); chk("status_sticky", {24'h0, rv}, 32'h02);
        repeat (3) @(negedge clk);
        chk("len0_stall", stall_cnt, 32'd0);
        chk("len0_sel", sel_cnt, 32'd0);
        wr(3'd6, 8'h01);
        chk("len0_irq_masked", {31'd0, irq}, 32'd0);

        // Source wrap at 0xFFFF, with REQ held off two cycles by a CPU write
        mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
        exp_q.push_back({16'h8100, 8'hAB});
        exp_q.push_back({16'h8101, 8'hCD});
        setup(16'hFFFF, 16'h8100, 16'd2);
        stall_cnt = 0;
        cpu_we = 1'b1;
        wr(3'd6, 8'h01);
        repeat (2) @(negedge clk);
        cpu_we = 1'b0;
        wait_idle();
        chk("wrap_stall", stall_cnt, 32'd11);
        chk("wrap_mem1", {24'h0, mem[16'h8101]}, 32'hCD);
        rd(3'd0, rv); chk("wrap_src_lo", {24'h0, rv}, 32'h01);
        rd(3'd1, rv); chk("wrap_src_hi", {24'h0, rv}, 32'h00);

        // Abort after the first byte of five
        for (int i = 0; i < 5; i++) begin
            mem[16'h9200 + i] = 8'h50 + 8'(i);
            mem[16'h8200 + i] = 8'hEE;
        end
        exp_q.push_back({16'h8200, 8'h50});
        setup(16'h9200, 16'h8200, 16'd5);
        wr(3'd6, 8'h01);
        wait_we();
        wr(3'd6, 8'h00);
        wait_idle();
        chk("abort_sel", {31'd0, bus_sel}, 32'd0);
        rd(3'd7, rv); chk("abort_status", {24'h0, rv}, 32'h02);
        rd(3'd4, rv); chk("abort_len", {24'h0, rv}, 32'h04);
        chk("abort_mem1", {24'h0, mem[16'h8201]}, 32'hEE);

        // Reset while in WR
        exp_q.push_back({16'h8300, 8'h00});
        setup(16'h9300, 16'h8300, 16'd3);
        wr(3'd6, 8'h01);
        wait_we();
        rst = 1'b1;
        @(negedge clk);
        chk("rstwr_sel", {31'd0, bus_sel}, 32'd0);
        chk("rstwr_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("rstwr_we", {31'd0, dma_we}, 32'd0);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rd(3'(r), rv);
            chk("rstwr_reg", {24'h0, rv}, 32'd0);
        end

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
